// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       isZero;
  logic [2:0] ALUoperations;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic [1:0] PCSrc;
  logic       pc_en;
  logic       illegal_instr;
  logic [3:0] state_out;

  modport master (
    input  opcode, funct, isZero,
    output ALUoperations, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, pc_en, illegal_instr, state_out
  );

  modport slave (
    output opcode, funct, isZero,
    input  ALUoperations, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCSrc, pc_en, illegal_instr, state_out
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control FSM: Moore decode of state plus opcode/funct, Mealy pc_en in BEQEX/BNEEX.
// Optional bne support is enabled by defining the macro BNE_SUPPORT_EN.
module multicycle_control_fsm #(
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_control_fsm_if.master      bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_SUPPORT_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef struct packed {
    logic       legal;
    logic       shift;
    logic [2:0] op;
  } funct_dec_t;

  function automatic funct_dec_t decode_funct(input logic [5:0] f);
    funct_dec_t d;
    d = '{legal: 1'b1, shift: 1'b0, op: 3'b010};
    case (f)
      6'b100000: d.op = 3'b010;
      6'b100010: d.op = 3'b110;
      6'b100100: d.op = 3'b000;
      6'b100101: d.op = 3'b001;
      6'b101010: d.op = 3'b111;
      6'b100111: d.op = 3'b011;
      6'b000000: begin d.op = 3'b100; d.shift = 1'b1; end
      6'b000010: begin d.op = 3'b101; d.shift = 1'b1; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_t     r_state;
  state_t     w_next;
  funct_dec_t w_fd;
  logic [2:0] w_aluop;
  logic [1:0] w_srca, w_srcb, w_pcsrc;
  logic       w_iord, w_memrd, w_memwr, w_irwr, w_regdst, w_memtoreg, w_regwr;
  logic       w_pcen, w_illegal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_fd       = decode_funct(bus.funct);
    w_aluop    = 3'b010;
    w_srca     = 2'b00;
    w_srcb     = 2'b00;
    w_pcsrc    = 2'b00;
    w_iord     = 1'b0;
    w_memrd    = 1'b0;
    w_memwr    = 1'b0;
    w_irwr     = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwr    = 1'b0;
    w_pcen     = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memrd = 1'b1;
        w_irwr  = 1'b1;
        w_srcb  = 2'b01;
        w_pcen  = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        w_srcb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       w_next = S_BNEEX;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_memrd = 1'b1;
        w_iord  = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwr    = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        w_memwr = 1'b1;
        w_iord  = 1'b1;
      end
      S_RTYPEEX: begin
        w_srca    = w_fd.shift ? 2'b10 : 2'b01;
        w_aluop   = w_fd.op;
        w_illegal = ~w_fd.legal;
        w_next    = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        // funct is held by the IR, so legality is re-derived here to suppress the write
        w_regdst = 1'b1;
        w_regwr  = w_fd.legal;
      end
      S_BEQEX: begin
        w_srca  = 2'b01;
        w_aluop = 3'b110;
        w_pcsrc = 2'b01;
        w_pcen  = bus.isZero;
      end
`ifdef BNE_SUPPORT_EN
      S_BNEEX: begin
        w_srca  = 2'b01;
        w_aluop = 3'b110;
        w_pcsrc = 2'b01;
        w_pcen  = ~bus.isZero;
      end
`endif
      S_ADDIEX: begin
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_next = S_ADDIWB;
      end
      S_ADDIWB: w_regwr = 1'b1;
      S_JEX: begin
        w_pcsrc = 2'b10;
        w_pcen  = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.ALUoperations = w_aluop;
  assign bus.ALUSrcA       = w_srca;
  assign bus.ALUSrcB       = w_srcb;
  assign bus.IorD          = w_iord;
  assign bus.MemRead       = w_memrd;
  assign bus.MemWrite      = w_memwr;
  assign bus.IRWrite       = w_irwr;
  assign bus.RegDst        = w_regdst;
  assign bus.MemtoReg      = w_memtoreg;
  assign bus.RegWrite      = w_regwr;
  assign bus.PCSrc         = w_pcsrc;
  assign bus.pc_en         = w_pcen;
  assign bus.illegal_instr = w_illegal;
  assign bus.state_out     = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle expected state/control words queued per instruction.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  multicycle_control_fsm_if ifc0();
  multicycle_control_fsm_if ifc1();

  multicycle_control_fsm #(.ILLEGAL_TRAP(0)) dut0 (.clk(clk), .reset(rst0), .bus(ifc0));
  multicycle_control_fsm #(.ILLEGAL_TRAP(1)) dut1 (.clk(clk), .reset(rst1), .bus(ifc1));

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Control word layout: ALUop, SrcA, SrcB, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCSrc, pc_en, illegal
  function automatic logic [17:0] ctl(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                                      input logic iord, input logic mr, input logic mw, input logic irw,
                                      input logic rd, input logic m2r, input logic rw,
                                      input logic [1:0] pcs, input logic pce, input logic ill);
    return {op, a, b, iord, mr, mw, irw, rd, m2r, rw, pcs, pce, ill};
  endfunction

  function automatic logic [17:0] obs_ctl(input int sel);
    if (sel == 0)
      return ctl(ifc0.ALUoperations, ifc0.ALUSrcA, ifc0.ALUSrcB, ifc0.IorD, ifc0.MemRead, ifc0.MemWrite,
                 ifc0.IRWrite, ifc0.RegDst, ifc0.MemtoReg, ifc0.RegWrite, ifc0.PCSrc, ifc0.pc_en,
                 ifc0.illegal_instr);
    return ctl(ifc1.ALUoperations, ifc1.ALUSrcA, ifc1.ALUSrcB, ifc1.IorD, ifc1.MemRead, ifc1.MemWrite,
               ifc1.IRWrite, ifc1.RegDst, ifc1.MemtoReg, ifc1.RegWrite, ifc1.PCSrc, ifc1.pc_en,
               ifc1.illegal_instr);
  endfunction

  function automatic logic [3:0] obs_st(input int sel);
    return (sel == 0) ? ifc0.state_out : ifc1.state_out;
  endfunction

  task automatic push(input logic [3:0] st, input logic [17:0] c);
    exp_t e;
    e.st  = st;
    e.ctl = c;
    sb.push_back(e);
  endtask

  task automatic drain(input int sel, input string tag, input bit expect_fetch);
    exp_t        e;
    logic [17:0] o;
    int          cyc = 0;
    while (sb.size() > 0) begin
      #1;
      e = sb.pop_front();
      o = obs_ctl(sel);
      check_eq($sformatf("%s_c%0d_state", tag, cyc), obs_st(sel), e.st);
      check_eq($sformatf("%s_c%0d_ctl", tag, cyc), o, e.ctl);
      check_eq($sformatf("%s_c%0d_mw_rw_excl", tag, cyc), o[8] & o[4], 0);
      cyc++;
      @(negedge clk);
    end
    if (expect_fetch) begin
      #1;
      check_eq({tag, "_back_to_fetch"}, obs_st(sel), 0);
    end
  endtask

  logic [17:0] c_fetch, c_dec, c_dec_ill, c_memadr, c_none;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    c_fetch   = ctl(3'b010, 2'b00, 2'b01, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1, 0);
    c_dec     = ctl(3'b010, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    c_dec_ill = ctl(3'b010, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    c_memadr  = ctl(3'b010, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    c_none    = ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    rst0 = 1'b1; rst1 = 1'b1;
    ifc0.opcode = 6'b000000; ifc0.funct = 6'b100000; ifc0.isZero = 1'b0;
    ifc1.opcode = 6'b111111; ifc1.funct = 6'b000000; ifc1.isZero = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_state", ifc0.state_out, 0);
    check_eq("reset_ctl", obs_ctl(0), c_fetch);
    @(negedge clk);
    rst0 = 1'b0;

    // lw interrupted by reset while in MEMRD
    ifc0.opcode = 6'b100011;
    push(4'd0, c_fetch); push(4'd1, c_dec); push(4'd2, c_memadr);
    drain(0, "lw_pre", 1'b0);
    #1;
    check_eq("lw_pre_memrd_state", ifc0.state_out, 3);
    rst0 = 1'b1;
    @(negedge clk); #1;
    check_eq("rst_mid_state1", ifc0.state_out, 0);
    check_eq("rst_mid_regwrite1", ifc0.RegWrite, 0);
    @(negedge clk); #1;
    check_eq("rst_mid_state2", ifc0.state_out, 0);
    check_eq("rst_mid_regwrite2", ifc0.RegWrite, 0);
    rst0 = 1'b0;

    // full lw
    push(4'd0, c_fetch); push(4'd1, c_dec); push(4'd2, c_memadr);
    push(4'd3, ctl(3'b010, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    push(4'd4, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0));
    drain(0, "lw", 1'b1);
    @(negedge clk);

    // sw (resync to a FETCH-cycle negedge first: previous drain ended there, the extra edge ran one FETCH->DECODE)
    rst0 = 1'b1; @(negedge clk); rst0 = 1'b0;
    ifc0.opcode = 6'b101011;
    push(4'd0, c_fetch); push(4'd1, c_dec); push(4'd2, c_memadr);
    push(4'd5, ctl(3'b010, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0));
    drain(0, "sw", 1'b1);

    // R-type: sub, slt, sll, illegal funct
    ifc0.opcode = 6'b000000; ifc0.funct = 6'b100010;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd6, ctl(3'b110, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    push(4'd7, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0));
    drain(0, "sub", 1'b1);

    ifc0.funct = 6'b101010;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd6, ctl(3'b111, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    push(4'd7, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0));
    drain(0, "slt", 1'b1);

    ifc0.funct = 6'b000000;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd6, ctl(3'b100, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    push(4'd7, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0));
    drain(0, "sll", 1'b1);

    ifc0.funct = 6'b111111;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd6, ctl(3'b010, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
    push(4'd7, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    drain(0, "badfunct", 1'b1);

    // beq taken / not taken
    ifc0.opcode = 6'b000100; ifc0.isZero = 1'b1;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd8, ctl(3'b110, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0));
    drain(0, "beq_taken", 1'b1);

    ifc0.isZero = 1'b0;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd8, ctl(3'b110, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0));
    drain(0, "beq_not", 1'b1);

    // addi
    ifc0.opcode = 6'b001000;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd9, c_memadr);
    push(4'd10, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0));
    drain(0, "addi", 1'b1);

    // j
    ifc0.opcode = 6'b000010;
    push(4'd0, c_fetch); push(4'd1, c_dec);
    push(4'd11, ctl(3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0));
    drain(0, "j", 1'b1);

    // unknown opcode, no trap
    ifc0.opcode = 6'b111111;
    push(4'd0, c_fetch); push(4'd1, c_dec_ill);
    drain(0, "illegal_op", 1'b1);

    // bne
    ifc0.opcode = 6'b000101; ifc0.isZero = 1'b0;
    push(4'd0, c_fetch);
`ifdef BNE_SUPPORT_EN
    push(4'd1, c_dec);
    push(4'd12, ctl(3'b110, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0));
`else
    push(4'd1, c_dec_ill);
`endif
    drain(0, "bne", 1'b1);

    // trap instance: unknown opcode halts until reset
    rst1 = 1'b0;
    push(4'd0, c_fetch); push(4'd1, c_dec_ill);
    for (int i = 0; i < 10; i++) push(4'd15, c_none);
    drain(1, "trap", 1'b0);
    #1;
    check_eq("trap_still_halt", ifc1.state_out, 15);
    rst1 = 1'b1;
    @(negedge clk); #1;
    check_eq("trap_reset_exit", ifc1.state_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath; generates the `ALUoperations` code and all mux, write-enable and PC controls that the datapath ALU and register files consume.
- Inputs are the latched instruction fields plus the ALU `isZero` flag. One instruction completes every 3–5 cycles.
- Sits between the instruction register and the datapath.

Parameters:
- ILLEGAL_TRAP, 0, 0: an unknown opcode returns to FETCH; 1: it enters HALT until reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from the IR; stable from DECODE onward
- funct  in  6  instr[5:0] from the IR
- isZero  in  1  ALU zero flag, same cycle
- ALUoperations  out  3  ALU code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 NOR, 100 SLL (operend2<<operend1), 101 SRL
- ALUSrcA  out  2  operand1 select: 00 PC, 01 regA, 10 zero-extended shamt
- ALUSrcB  out  2  operand2 select: 00 regB, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate <<2
- IorD  out  1  memory address select: 0 PC, 1 ALUOut
- MemRead / MemWrite / IRWrite  out  1 each  memory and IR enables
- RegDst  out  1  1 selects rd, 0 selects rt
- MemtoReg  out  1  1 selects MDR, 0 selects ALUOut
- RegWrite  out  1  register file write enable
- PCSrc  out  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target
- pc_en  out  1  PC load enable (branch condition already folded in)
- illegal_instr  out  1  one-cycle pulse on an unknown opcode or funct
- state_out  out  4  current state, for debug

Behaviour:
- Single clock domain; reset is synchronous and active-high. The state register updates on the rising edge of clk.
- On reset the state becomes FETCH and all registered outputs go to 0. Reset beats any in-flight instruction: no partial write-back occurs after the reset edge.
- All outputs are a decode of the current state (Moore) plus opcode/funct, with one exception: pc_en in BEQEX is Mealy on isZero.
- Any output not listed for a state is 0. ALUoperations defaults to 010.

State machine (encoding in brackets):
- FETCH(0): MemRead, IRWrite, ALUSrcA=00, ALUSrcB=01, ADD, PCSrc=00, pc_en=1. Next state DECODE.
- DECODE(1): ALUSrcA=00, ALUSrcB=11, ADD (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - anything else → illegal_instr=1 that cycle, then FETCH (or HALT when ILLEGAL_TRAP=1)
- MEMADR(2): ALUSrcA=01, ALUSrcB=10, ADD. Next state MEMRD for lw, MEMWR for sw.
- MEMRD(3): MemRead, IorD=1. Next state MEMWB.
- MEMWB(4): RegWrite, RegDst=0, MemtoReg=1. Next state FETCH.
- MEMWR(5): MemWrite, IorD=1. Next state FETCH.
- RTYPEEX(6): ALUSrcB=00. ALUSrcA=10 for sll/srl, else 01. Funct to ALUoperations:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - 100111 → 011
  - 000000 → 100
  - 000010 → 101
  - other → 010 with illegal_instr=1
  - Next state RTYPEWB.
- RTYPEWB(7): RegDst=1, MemtoReg=0. RegWrite=1 only when funct is legal; an illegal funct gives no write. Next state FETCH.
- BEQEX(8): ALUSrcA=01, ALUSrcB=00, SUB, PCSrc=01, pc_en=isZero. Next state FETCH.
- ADDIEX(9): ALUSrcA=01, ALUSrcB=10, ADD. Next state ADDIWB.
- ADDIWB(10): RegWrite, RegDst=0, MemtoReg=0. Next state FETCH.
- JEX(11): PCSrc=10, pc_en=1. Next state FETCH.
- HALT(15): all enables 0; stays in HALT until reset.
- Unused encodings go to FETCH on the next edge.

Latency, counted from entering FETCH to entering the next FETCH:
- lw 5 cycles
- sw, R-type, addi 4 cycles
- beq, j 3 cycles

Enable invariants:
- MemWrite and RegWrite are never both 1.
- pc_en is asserted only in FETCH, BEQEX, JEX and BNEEX.

Optional Feature:
- Macro BNE_SUPPORT_EN.
- Defined: opcode 000101 (bne) in DECODE goes to BNEEX(12). BNEEX has the same outputs as BEQEX except pc_en=~isZero; next state FETCH.
- Undefined: opcode 000101 is illegal (illegal_instr pulse, FETCH or HALT); state 12 is unused.

Test Plan:
- Reset held 2 cycles mid-MEMRD, then released → state_out=0, RegWrite never asserted, first cycle shows MemRead=1, IRWrite=1, pc_en=1, ALUoperations=010.
- opcode=100011 → states 0,1,2,3,4,0. RegWrite=1 with MemtoReg=1 only in state 4. ALUSrcB=10 in state 2.
- opcode=000000 with funct 100010, 101010, 000000 in turn → RTYPEEX ALUoperations=110, 111, 100. ALUSrcA=10 for sll. RegDst=1 in RTYPEWB.
- opcode=000100: isZero=1 gives pc_en=1, PCSrc=01 in state 8; isZero=0 gives pc_en=0. Both return to FETCH after 3 cycles.
- opcode=111111 with ILLEGAL_TRAP=0 → one-cycle illegal_instr pulse, then FETCH. With ILLEGAL_TRAP=1 → state 15 held for 10 cycles with no enables; reset leaves it.
- With BNE_SUPPORT_EN defined and opcode=000101, isZero=0 → state 12, pc_en=1. Without the macro → illegal_instr=1.
